// File: rtl/multi_edge_detector.sv
// Purpose : per-channel synchroniser, glitch filter and mode-selected edge detector with
//           sticky flags, a combined interrupt and a saturating event counter.
// Latency : a din change stable from sampling edge 0 gives edge_rise/edge_fall/edge_pulse
//           SYNC_STAGES+FILTER_CYCLES rising edges later (edge 0 included). Flags and the
//           counter follow one edge after the pulse.
// Backpressure: none. Events are pulses, and nothing is lost while the counter is cleared.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high; clears every register
//   din         raw asynchronous inputs, one per channel
//   mode        per-channel mode, bits [2i+1:2i] = {fall_en, rise_en}
//               (00 off, 01 rise, 10 fall, 11 both)
//   flag_clr    one-cycle clear strobe per sticky flag (a same-cycle set wins)
//   cnt_clr     one-cycle counter clear (same-cycle events are still counted)
//   level       filtered level per channel
//   edge_pulse  one-cycle pulse for each transition enabled by mode
//   edge_rise   one-cycle pulse for each filtered rising transition
//   edge_fall   one-cycle pulse for each filtered falling transition
//   event_flag  sticky event flags
//   irq         OR of event_flag
//   event_count saturating total of edge_pulse bits
module multi_edge_detector #(
   parameter int CHANNELS      = 8,
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 4,
   parameter int CNT_WIDTH     = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [CHANNELS-1:0]   din,
   input  logic [2*CHANNELS-1:0] mode,
   input  logic [CHANNELS-1:0]   flag_clr,
   input  logic                  cnt_clr,
   output logic [CHANNELS-1:0]   level,
   output logic [CHANNELS-1:0]   edge_pulse,
   output logic [CHANNELS-1:0]   edge_rise,
   output logic [CHANNELS-1:0]   edge_fall,
   output logic [CHANNELS-1:0]   event_flag,
   output logic                  irq,
   output logic [CNT_WIDTH-1:0]  event_count
);

   // Filter counter width: enough to hold FILTER_CYCLES.
   localparam int FCW = $clog2(FILTER_CYCLES + 1);
   // Popcount width: enough to hold CHANNELS.
   localparam int PCW = $clog2(CHANNELS + 1);
   // The counter sum needs one bit more than its wider operand so saturation can be seen.
   localparam int SUMW = ((CNT_WIDTH > PCW) ? CNT_WIDTH : PCW) + 1;

   localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_CYCLES - 1);

   // ------------------------------------------------------------------
   // Synchroniser: stage 0 samples din, the last stage feeds the filter.
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
   logic [CHANNELS-1:0]                  sync;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];

   // ------------------------------------------------------------------
   // Glitch filter. The counter counts consecutive cycles where the
   // synchronised input disagrees with the filtered level. Any
   // agreement restarts it, so only a run of FILTER_CYCLES mismatches
   // moves the level.
   // ------------------------------------------------------------------
   logic [CHANNELS-1:0][FCW-1:0] filt_cnt;
   logic [CHANNELS-1:0][FCW-1:0] filt_cnt_nxt;
   logic [CHANNELS-1:0]          level_nxt;
   logic [CHANNELS-1:0]          change;

   always_comb begin
      filt_cnt_nxt = filt_cnt;
      level_nxt    = level;
      change       = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (sync[i] == level[i]) begin
            filt_cnt_nxt[i] = '0;
         end else if (filt_cnt[i] == FILT_LAST) begin
            level_nxt[i]    = sync[i];
            filt_cnt_nxt[i] = '0;
            change[i]       = 1'b1;
         end else begin
            filt_cnt_nxt[i] = filt_cnt[i] + FCW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         filt_cnt <= '0;
         level    <= '0;
      end else begin
         filt_cnt <= filt_cnt_nxt;
         level    <= level_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Transition and event detection. The next-state values are built
   // from the level update itself, so the pulses line up with the edge
   // where level changes. Mode is sampled only at that edge, so a mode
   // change never disturbs the filter.
   // ------------------------------------------------------------------
   logic [CHANNELS-1:0] mode_rise;
   logic [CHANNELS-1:0] mode_fall;
   logic [CHANNELS-1:0] rise_nxt;
   logic [CHANNELS-1:0] fall_nxt;
   logic [CHANNELS-1:0] pulse_nxt;

   always_comb begin
      mode_rise = '0;
      mode_fall = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         mode_rise[i] = mode[2*i];
         mode_fall[i] = mode[2*i+1];
      end
   end

   assign rise_nxt  = change &  level_nxt;
   assign fall_nxt  = change & ~level_nxt;
   assign pulse_nxt = (rise_nxt & mode_rise) | (fall_nxt & mode_fall);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         edge_rise  <= '0;
         edge_fall  <= '0;
         edge_pulse <= '0;
      end else begin
         edge_rise  <= rise_nxt;
         edge_fall  <= fall_nxt;
         edge_pulse <= pulse_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Sticky flags: the clear is applied before the set, so an event in
   // the same cycle as its clear leaves the flag set.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         event_flag <= '0;
      end else begin
         event_flag <= (event_flag & ~flag_clr) | edge_pulse;
      end
   end

   assign irq = |event_flag;

   // ------------------------------------------------------------------
   // Saturating event counter. A clear replaces the old total with zero
   // but still adds this cycle's pulses, so no event slips through.
   // ------------------------------------------------------------------
   function automatic logic [PCW-1:0] popcount(input logic [CHANNELS-1:0] v);
      logic [PCW-1:0] n;
      n = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         n = n + PCW'(v[i]);
      end
      return n;
   endfunction

   logic [PCW-1:0]       pulse_pop;
   logic [SUMW-1:0]      cnt_base;
   logic [SUMW-1:0]      cnt_sum;
   logic [SUMW-1:0]      cnt_max;
   logic [CNT_WIDTH-1:0] cnt_nxt;

   always_comb begin
      pulse_pop = popcount(edge_pulse);
      cnt_base  = '0;
      if (!cnt_clr) begin
         cnt_base[CNT_WIDTH-1:0] = event_count;
      end
      cnt_sum = cnt_base + SUMW'(pulse_pop);
      cnt_max = '0;
      cnt_max[CNT_WIDTH-1:0] = '1;
      if (cnt_sum > cnt_max) begin
         cnt_nxt = '1;
      end else begin
         cnt_nxt = cnt_sum[CNT_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         event_count <= '0;
      end else begin
         event_count <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_multi_edge_detector.sv
module tb_multi_edge_detector;

   localparam int CH    = 8;
   localparam int SYNC  = 2;
   localparam int FC    = 4;
   localparam int CW    = 4;
   localparam int DEPTH = SYNC + FC - 1;
   localparam int CMAX  = (1 << CW) - 1;

   logic          clk;
   logic          reset;
   logic [CH-1:0] din;
   logic [2*CH-1:0] mode;
   logic [CH-1:0] flag_clr;
   logic          cnt_clr;
   logic [CH-1:0] level, edge_pulse, edge_rise, edge_fall, event_flag;
   logic          irq;
   logic [CW-1:0] event_count;

   multi_edge_detector #(
      .CHANNELS(CH), .SYNC_STAGES(SYNC), .FILTER_CYCLES(FC), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .reset(reset), .din(din), .mode(mode), .flag_clr(flag_clr),
      .cnt_clr(cnt_clr), .level(level), .edge_pulse(edge_pulse), .edge_rise(edge_rise),
      .edge_fall(edge_fall), .event_flag(event_flag), .irq(irq), .event_count(event_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [CH-1:0] level;
      logic [CH-1:0] rise;
      logic [CH-1:0] fall;
      logic [CH-1:0] pulse;
      logic [CH-1:0] flag;
      logic          irq;
      logic [CW-1:0] count;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_err = 0;
   logic done  = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model. hist[j] holds the din value sampled j+1 edges ago.
   // The filtered level flips to v when the FC synchronised samples
   // (SYNC..SYNC+FC-1 edges old) all equal v and differ from the level.
   // ------------------------------------------------------------------
   logic [CH-1:0] hist [DEPTH];
   logic [CH-1:0] m_level, m_rise, m_fall, m_pulse, m_flag;
   int            m_count;
   logic [CH-1:0] cur_din;
   logic [2*CH-1:0] cur_mode;

   task automatic model_step(input logic rst, input logic [CH-1:0] d, input logic [2*CH-1:0] md,
                             input logic [CH-1:0] fc, input logic cc);
      exp_t e;
      logic v, stable;
      if (rst) begin
         for (int j = 0; j < DEPTH; j++) hist[j] = '0;
         m_level = '0; m_rise = '0; m_fall = '0; m_pulse = '0; m_flag = '0; m_count = 0;
      end else begin
         // flags and count react to the pulse already on the outputs
         m_flag  = (m_flag & ~fc) | m_pulse;
         m_count = (cc ? 0 : m_count) + $countones(m_pulse);
         if (m_count > CMAX) m_count = CMAX;
         m_rise = '0; m_fall = '0; m_pulse = '0;
         for (int c = 0; c < CH; c++) begin
            v = hist[SYNC-1][c];
            stable = 1'b1;
            for (int k = 0; k < FC; k++)
               if (hist[SYNC-1+k][c] != v) stable = 1'b0;
            if (stable && v != m_level[c]) begin
               m_level[c] = v;
               m_rise[c]  = v;
               m_fall[c]  = ~v;
               m_pulse[c] = v ? md[2*c] : md[2*c+1];
            end
         end
         for (int j = DEPTH-1; j > 0; j--) hist[j] = hist[j-1];
         hist[0] = d;
      end
      e.level = m_level; e.rise = m_rise; e.fall = m_fall; e.pulse = m_pulse;
      e.flag = m_flag; e.irq = |m_flag; e.count = CW'(m_count);
      sbq.push_back(e);
   endtask

   // One clock of stimulus: drive at the falling edge, predict the next rising edge.
   task automatic cyc(input logic rst, input logic [CH-1:0] d, input logic [2*CH-1:0] md,
                      input logic [CH-1:0] fc, input logic cc);
      @(negedge clk);
      reset = rst; din = d; mode = md; flag_clr = fc; cnt_clr = cc;
      cur_din = d; cur_mode = md;
      model_step(rst, d, md, fc, cc);
      if (rst) begin
         #1;
         chk("async_reset", {level, edge_pulse, edge_rise, edge_fall},  32'h0);
         chk("async_reset_flags", {event_flag, irq, event_count}, 32'h0);
      end
   endtask

   task automatic hold(input logic [CH-1:0] d, input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, d, cur_mode, '0, 1'b0);
   endtask

   // Counts edges from the first sampling edge until edge_rise shows d.
   task automatic latency_check(input logic [CH-1:0] d, input int want, input string nm);
      int seen;
      seen = 0;
      for (int k = 1; k <= 20; k++) begin
         cyc(1'b0, d, cur_mode, '0, 1'b0);
         @(posedge clk); #1;
         if (seen == 0 && edge_rise == d) seen = k;
      end
      chk(nm, seen, want);
   endtask

   // Monitor: compares every registered output whenever a prediction is due.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk); #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("level",       level,       e.level);
            chk("edge_rise",   edge_rise,   e.rise);
            chk("edge_fall",   edge_fall,   e.fall);
            chk("edge_pulse",  edge_pulse,  e.pulse);
            chk("event_flag",  event_flag,  e.flag);
            chk("irq",         irq,         e.irq);
            chk("event_count", event_count, e.count);
         end
      end
   end

   initial begin
      #1000000;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      logic [CH-1:0] fc;
      logic cc, rst;
      int   rst_left;

      reset = 1'b1; din = 8'hFF; mode = 16'h5555; flag_clr = '0; cnt_clr = 1'b0;
      cur_din = din; cur_mode = mode;
      for (int j = 0; j < DEPTH; j++) hist[j] = '0;
      m_level = '0; m_rise = '0; m_fall = '0; m_pulse = '0; m_flag = '0; m_count = 0;
      #1;
      chk("reset_state", {level, edge_pulse, edge_rise, edge_fall}, 32'h0);
      chk("reset_state_flags", {event_flag, irq, event_count}, 32'h0);

      // Input high through reset: rise reported on the sixth edge after release.
      for (int k = 0; k < 3; k++) cyc(1'b1, 8'hFF, 16'h5555, '0, 1'b0);
      latency_check(8'hFF, 6, "rise_latency");
      chk("first_flags", event_flag, 8'hFF);
      chk("first_irq", irq, 1);
      chk("first_count", event_count, 8);
      cyc(1'b0, 8'hFF, cur_mode, 8'hFF, 1'b1);

      // Glitch rejection on ch0, then a long enough pulse.
      hold(8'h00, 10);
      hold(8'h01, 3);
      hold(8'h00, 10);
      @(posedge clk); #1;
      chk("glitch_level0", level[0], 0);
      hold(8'h01, 10);
      @(posedge clk); #1;
      chk("held_level0", level[0], 1);

      // Per-channel modes: ch0 off, ch1 rise, ch2 fall, ch3 both.
      cur_mode = 16'h00E4;
      hold(8'h00, 10);
      hold(8'h0F, 10);
      hold(8'h00, 10);

      // Clear racing a new event on ch1: the set wins.
      cur_mode = 16'h0005;
      cyc(1'b0, 8'h00, cur_mode, 8'hFF, 1'b0);
      hold(8'h00, 4);
      for (int k = 0; k < 12; k++) begin
         fc = '0;
         fc[1] = m_pulse[1];
         cyc(1'b0, 8'h02, cur_mode, fc, 1'b0);
      end
      @(posedge clk); #1;
      chk("race_flag1", event_flag[1], 1);
      cyc(1'b0, 8'h02, cur_mode, 8'h02, 1'b0);
      @(posedge clk); #1;
      chk("cleared_flags", event_flag, 0);
      chk("cleared_irq", irq, 0);

      // Counter clear coinciding with a two-channel pulse.
      hold(8'h00, 10);
      for (int k = 0; k < 12; k++) begin
         cc = ($countones(m_pulse) == 2);
         cyc(1'b0, 8'h03, cur_mode, '0, cc);
         if (cc) begin
            @(posedge clk); #1;
            chk("cnt_clr_pop", event_count, 2);
         end
      end

      // Saturation: every channel on both edges, well over 15 events.
      cur_mode = 16'hFFFF;
      for (int t = 0; t < 3; t++) begin
         hold(8'hFF, 8);
         hold(8'h00, 8);
      end
      @(posedge clk); #1;
      chk("count_sat", event_count, CMAX);
      hold(8'hFF, 8);
      @(posedge clk); #1;
      chk("count_hold", event_count, CMAX);

      // Reset mid-filter with flags set, then full-latency re-detection.
      cur_mode = 16'h5555;
      hold(8'h00, 10);
      hold(8'hFF, 4);
      cyc(1'b1, 8'hFF, cur_mode, '0, 1'b0);
      cyc(1'b1, 8'hFF, cur_mode, '0, 1'b0);
      latency_check(8'hFF, 6, "rise_after_reset");

      // Randomised traffic.
      rst_left = 0;
      for (int k = 0; k < 2000; k++) begin
         logic [CH-1:0] d;
         logic [2*CH-1:0] md;
         d = cur_din;
         for (int c = 0; c < CH; c++)
            if ($urandom_range(7) == 0) d[c] = ~d[c];
         md = cur_mode;
         if ($urandom_range(63) == 0) md = 16'($urandom);
         fc = '0;
         for (int c = 0; c < CH; c++)
            if ($urandom_range(15) == 0) fc[c] = 1'b1;
         cc = ($urandom_range(31) == 0);
         if (rst_left == 0 && $urandom_range(499) == 0) rst_left = $urandom_range(2, 1);
         rst = (rst_left > 0);
         if (rst_left > 0) rst_left--;
         cyc(rst, d, md, fc, cc);
      end

      // Drain the scoreboard within a bounded number of cycles.
      for (int k = 0; k < 10 && sbq.size() > 0; k++) @(posedge clk);
      #2;
      chk("scoreboard_drained", sbq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/multi_edge_detector.md
Name: multi_edge_detector

Overview:
- Parametrised multi-channel edge detector that replaces single-bit, falling-edge-only detection.
- Each channel passes through:
  - a synchroniser;
  - a glitch filter;
  - a per-channel mode-selected edge detector (off, rise, fall or both).
- Produces registered one-cycle event pulses, sticky event flags with software clear, a combined interrupt and a saturating event counter.
- Sits between asynchronous external/slow-domain inputs (buttons, status lines) and control FSMs or interrupt logic.

Parameters:
- CHANNELS, 8: number of independent input channels (1..32).
- SYNC_STAGES, 2: synchroniser flops per channel (≥2).
- FILTER_CYCLES, 4: consecutive stable cycles required before the filtered level changes (≥1; 1 = no filtering).
- CNT_WIDTH, 8: width of the saturating event counter.

Ports:
- clk  in  1  system clock, rising-edge active.
- reset  in  1  asynchronous, active-high; clears all state.
- din  in  CHANNELS  raw asynchronous inputs.
- mode  in  2*CHANNELS  per-channel mode; bits [2i+1:2i] for channel i.
  - 00: off; 01: rising; 10: falling; 11: both.
- flag_clr  in  CHANNELS  one-cycle clear strobe per sticky flag.
- cnt_clr  in  1  one-cycle counter clear.
- level  out  CHANNELS  filtered level per channel.
- edge_pulse  out  CHANNELS  one-cycle detected-event pulse.
- edge_rise  out  CHANNELS  one-cycle pulse, filtered rising transition (mode-independent).
- edge_fall  out  CHANNELS  one-cycle pulse, filtered falling transition (mode-independent).
- event_flag  out  CHANNELS  sticky event flags.
- irq  out  1  OR of event_flag.
- event_count  out  CNT_WIDTH  saturating total of edge_pulse bits.

Behaviour:
- **Reset.** Clock is clk; reset is asynchronous, active-high. Reset clears all of the following to 0:
  - synchroniser flops, filter counters and level;
  - edge_pulse, edge_rise, edge_fall;
  - event_flag, irq, event_count.
  Input high during reset produces a rising event after reset release plus latency. Reset mid-filter discards the partial count.
- **Synchroniser.** s[0] <= din, s[k] <= s[k-1]. sync = s[SYNC_STAGES-1].
- **Filter (per channel).** cnt is ceil(log2(FILTER_CYCLES+1)) bits.
  - If sync == level: cnt <= 0.
  - Else if cnt == FILTER_CYCLES-1: level <= sync, cnt <= 0.
  - Else: cnt <= cnt+1.
  - A glitch shorter than FILTER_CYCLES synchronised cycles never changes level.
- **Transition pulses.**
  - At the same edge level updates: edge_rise[i] <= new level; edge_fall[i] <= ~new level.
  - Both are 0 at all other edges, so each pulse lasts exactly one cycle.
- **Detected event.** edge_pulse[i] <= (edge_rise_next & mode[2i]) | (edge_fall_next & mode[2i+1]).
  - Mode is sampled at the edge the level changes.
  - Mode changes never disturb filter state.
- **Latency.** A din change that is stable from sampling edge 0 produces edge_rise/edge_fall/edge_pulse high after SYNC_STAGES+FILTER_CYCLES rising edges, for one cycle.
- **Sticky flags.**
  - event_flag[i] sets on edge_pulse[i].
  - flag_clr[i] clears it.
  - Simultaneous set and clear: set wins (flag stays 1).
  - irq = |event_flag, combinational from registered flags.
- **Counter.** event_count <= sat(event_count + popcount(edge_pulse)). It holds at 2^CNT_WIDTH-1 and never wraps.
  - cnt_clr: event_count <= popcount(edge_pulse) of that cycle, so same-cycle events are not lost.
- **Multiple channels** may pulse in the same cycle; each is handled independently.

Test Plan:
- Reset and rise, defaults, mode=all 01: hold reset, din=0xFF, release.
  - level, edge_rise, edge_pulse = 0xFF exactly 6 edges after first sample, for 1 cycle.
  - event_flag=0xFF, irq=1, event_count=8.
- Glitch reject, ch0: din[0] high for 3 cycles, then low.
  - No level change, no pulses.
  - Then held for 4 cycles: level[0]=1, single edge_rise[0] pulse.
- Modes: ch0..3 modes 00/01/10/11; toggle din[3:0] 0→F→0 with 10-cycle holds.
  - edge_pulse: ch0 never; ch1 on rise only; ch2 on fall only; ch3 on both.
  - edge_rise/edge_fall fire on all four channels.
- Sticky clear race: flag_clr[1] asserted in the same cycle as edge_pulse[1].
  - event_flag[1] stays 1.
  - Later clear with no event → 0; irq drops when all flags are 0.
- Counter saturation, CNT_WIDTH=4: generate 20 events.
  - event_count = 15 and holds.
  - cnt_clr coincident with a 2-channel pulse → event_count = 2.
- Reset mid-operation: assert reset while filter cnt=2 and flags set.
  - All outputs 0 immediately (async).
  - After release, with din still high, the rise is re-detected with full latency.
